// File: rtl/split_pkg.sv
// Shared definitions for the dispatch-stage splitter: RISC-V opcodes, execution
// classes and the handshake FSM state encoding.
package split_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_NOP    = 7'b0000000;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [1:0] {CLS_BRANCH, CLS_MEM, CLS_ALU, CLS_ILLEGAL} op_class_t;

  typedef enum logic [2:0] {StIdle, StReq, StAck, StRtz, StDrop} state_t;

endpackage

// File: rtl/split_decode.sv
// Combinational opcode-to-execution-class decoder, shared with the join blocks.
module split_decode
  import split_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    unique case (opcode)
      OP_BRANCH, OP_JAL:         op_class = CLS_BRANCH;
      OP_LOAD, OP_STORE:         op_class = CLS_MEM;
      OP_OP, OP_OP_IMM, OP_NOP:  op_class = CLS_ALU;
      OP_LUI:                    op_class = CLS_ILLEGAL; // U-type not routed yet
      default:                   op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/split_n_sync.sv
// N-way four-phase req/ack splitter: steers each upstream transaction to the unit
// owning its opcode class, drops illegal opcodes, and watches for missing acks.
module split_n_sync
  import split_pkg::*;
#(
  parameter int unsigned N_OUT     = 3,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CH_BRANCH = 0,
  parameter int unsigned CH_MEM    = 1,
  parameter int unsigned CH_ALU    = 2,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_in,
  input  logic [6:0]        opcode,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack_out,
  output logic [N_OUT-1:0]  req_out,
  input  logic [N_OUT-1:0]  ack_in,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              err_illegal,
  output logic              err_timeout
);

  localparam int unsigned SelW = $clog2(N_OUT);
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t            state_q, state_d;
  logic [SelW-1:0]   sel_q, sel_d, ch_idx;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              err_to_q, err_to_d;
  logic              err_ill_q, err_ill_d;
  op_class_t         op_class;
  logic              ack_sel, watching, watch_entry;

  split_decode u_decode (
    .opcode   (opcode),
    .op_class (op_class)
  );

  always_comb begin
    ch_idx = SelW'(CH_ALU);
    unique case (op_class)
      CLS_BRANCH: ch_idx = SelW'(CH_BRANCH);
      CLS_MEM:    ch_idx = SelW'(CH_MEM);
      default:    ch_idx = SelW'(CH_ALU);
    endcase
  end

  assign ack_sel = ack_in[sel_q];

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    data_d    = data_q;
    err_ill_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_in) begin
          sel_d  = ch_idx;
          data_d = data_in;
          if (op_class == CLS_ILLEGAL) begin
            state_d   = StDrop;
            err_ill_d = 1'b1;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq:   if (ack_sel)  state_d = StAck;
      StAck:   if (!req_in)  state_d = StRtz;
      StRtz:   if (!ack_sel) state_d = StIdle;
      StDrop:  if (!req_in)  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Watchdog covers both phases that wait on the downstream unit; it only flags.
  assign watching    = (state_q == StReq) || (state_q == StRtz);
  assign watch_entry = ((state_d == StReq) && (state_q != StReq)) ||
                       ((state_d == StRtz) && (state_q != StRtz));

  always_comb begin
    cnt_d    = cnt_q;
    err_to_d = err_to_q;
    if (TIMEOUT != 0) begin
      if (watch_entry) begin
        cnt_d = '0;
      end else if (watching && (cnt_q != CntW'(TIMEOUT))) begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_d == CntW'(TIMEOUT)) err_to_d = 1'b1;
      end
    end
  end

  always_comb begin
    req_out = '0;
    if ((state_q == StReq) || (state_q == StAck)) req_out = N_OUT'(1) << sel_q;
    ack_out = (state_q == StAck) || (state_q == StRtz) || (state_q == StDrop);
    busy    = (state_q != StIdle);
  end

  assign data_out    = data_q;
  assign err_illegal = err_ill_q;
  assign err_timeout = err_to_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      err_to_q  <= 1'b0;
      err_ill_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      err_to_q  <= err_to_d;
      err_ill_q <= err_ill_d;
    end
  end

endmodule

// File: tb/tb_split_n_sync.sv
// Self-checking bench for split_n_sync: decode table, randomised handshakes against
// a transaction-level model, and hand-written reset / watchdog / corner sequences.
module tb_split_n_sync;

  localparam int N  = 3;
  localparam int W  = 32;
  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_in;
  logic [6:0]   opcode;
  logic [W-1:0] data_in;
  logic         ack_out;
  logic [N-1:0] req_out;
  logic [N-1:0] ack_in;
  logic [W-1:0] data_out;
  logic         busy;
  logic         err_illegal;
  logic         err_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  split_n_sync #(
    .N_OUT   (N),
    .DATA_W  (W),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_in      (req_in),
    .opcode      (opcode),
    .data_in     (data_in),
    .ack_out     (ack_out),
    .req_out     (req_out),
    .ack_in      (ack_in),
    .data_out    (data_out),
    .busy        (busy),
    .err_illegal (err_illegal),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]   op;
    logic [W-1:0] data;
    logic [N-1:0] exp_req;
    logic         exp_illegal;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: channel chosen by class, -1 for opcodes that must be dropped.
  function automatic int model_ch(input logic [6:0] op);
    case (op)
      7'b1100011, 7'b1101111:             return 0;
      7'b0000011, 7'b0100011:             return 1;
      7'b0110011, 7'b0010011, 7'b0000000: return 2;
      default:                            return -1;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Random noise on unselected ack lines, selected line forced to lvl.
  task automatic drive_ack(input logic [N-1:0] sel_mask, input logic lvl);
    logic [N-1:0] junk;
    junk   = N'($urandom);
    ack_in = (junk & ~sel_mask) | (lvl ? sel_mask : '0);
  endtask

  task automatic do_txn(input logic [6:0] op, input logic [W-1:0] d,
                        input int dd, input int ud, input int rd);
    int           ch;
    logic [N-1:0] oh;
    ch = model_ch(op);
    oh = (ch >= 0) ? N'(1 << ch) : '0;
    opcode  = op;
    data_in = d;
    req_in  = 1'b1;
    drive_ack(oh, 1'b0);
    step();
    check("req_out_first", req_out, oh);
    check("data_out_capture", data_out, d);
    check("busy_first", busy, 1'b1);
    check("err_illegal_first", err_illegal, ch < 0);
    check("ack_out_first", ack_out, ch < 0);
    data_in = W'($urandom);
    if (ch < 0) begin
      repeat (ud + 1) begin
        step();
        check("drop_err_illegal_low", err_illegal, 1'b0);
        check("drop_ack_out", ack_out, 1'b1);
        check("drop_req_out", req_out, '0);
      end
      req_in = 1'b0;
      step();
      check("drop_done_ack", ack_out, 1'b0);
      check("drop_done_busy", busy, 1'b0);
    end else begin
      repeat (dd) begin
        drive_ack(oh, 1'b0);
        data_in = W'($urandom);
        step();
        check("req_wait_req_out", req_out, oh);
        check("req_wait_ack_out", ack_out, 1'b0);
        check("req_wait_data", data_out, d);
      end
      drive_ack(oh, 1'b1);
      step();
      check("ack_ack_out", ack_out, 1'b1);
      check("ack_req_out", req_out, oh);
      repeat (ud) begin
        drive_ack(oh, 1'b1);
        step();
        check("ack_hold", ack_out, 1'b1);
      end
      req_in = 1'b0;
      step();
      check("rtz_req_out", req_out, '0);
      check("rtz_ack_out", ack_out, 1'b1);
      repeat (rd) begin
        drive_ack(oh, 1'b1);
        step();
        check("rtz_hold", ack_out, 1'b1);
      end
      drive_ack(oh, 1'b0);
      step();
      check("done_ack_out", ack_out, 1'b0);
      check("done_busy", busy, 1'b0);
      check("done_req_out", req_out, '0);
      check("done_data_out", data_out, d);
      check("no_timeout", err_timeout, 1'b0);
    end
  endtask

  initial begin
    vec_t vecs[10];
    logic [6:0] pool[9];

    vecs[0] = '{7'b1100011, 32'hDEADBEEF, 3'b001, 1'b0};
    vecs[1] = '{7'b0000011, 32'h11111111, 3'b010, 1'b0};
    vecs[2] = '{7'b0110011, 32'h22222222, 3'b100, 1'b0};
    vecs[3] = '{7'b1101111, 32'h33333333, 3'b001, 1'b0};
    vecs[4] = '{7'b0100011, 32'h44444444, 3'b010, 1'b0};
    vecs[5] = '{7'b0010011, 32'h55555555, 3'b100, 1'b0};
    vecs[6] = '{7'b0000000, 32'h66666666, 3'b100, 1'b0};
    vecs[7] = '{7'b0110111, 32'h77777777, 3'b000, 1'b1};
    vecs[8] = '{7'b1111111, 32'h88888888, 3'b000, 1'b1};
    vecs[9] = '{7'b0010111, 32'h99999999, 3'b000, 1'b1};
    pool = '{7'b1100011, 7'b1101111, 7'b0000011, 7'b0100011, 7'b0110011,
             7'b0010011, 7'b0000000, 7'b0110111, 7'b1110011};

    rst_n   = 1'b0;
    req_in  = 1'b0;
    opcode  = '0;
    data_in = '0;
    ack_in  = '0;
    step();
    step();
    check("rst_req_out", req_out, '0);
    check("rst_ack_out", ack_out, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err_illegal", err_illegal, 1'b0);
    check("rst_err_timeout", err_timeout, 1'b0);
    check("rst_data_out", data_out, '0);
    rst_n = 1'b1;
    step();

    // Decode table, back to back; expectations written out by hand.
    for (int i = 0; i < 10; i++) begin
      opcode  = vecs[i].op;
      data_in = vecs[i].data;
      req_in  = 1'b1;
      ack_in  = '0;
      step();
      check("tbl_req_out", req_out, vecs[i].exp_req);
      check("tbl_err_illegal", err_illegal, vecs[i].exp_illegal);
      check("tbl_data_out", data_out, vecs[i].data);
      if (!vecs[i].exp_illegal) begin
        ack_in = vecs[i].exp_req;
        step();
        check("tbl_ack_out", ack_out, 1'b1);
      end else begin
        step();
        check("tbl_illegal_pulse_end", err_illegal, 1'b0);
        check("tbl_drop_ack_out", ack_out, 1'b1);
      end
      req_in = 1'b0;
      step();
      ack_in = '0;
      if (!vecs[i].exp_illegal) step();
      check("tbl_idle_ack_out", ack_out, 1'b0);
      check("tbl_idle_busy", busy, 1'b0);
    end

    // Randomised transactions against the model.
    for (int i = 0; i < 40; i++) begin
      logic [6:0] op;
      op = ($urandom_range(0, 4) == 0) ? 7'($urandom) : pool[$urandom_range(0, 8)];
      do_txn(op, W'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
             $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) step();
    end

    // Ack already high in IDLE: REQ is still visited for one cycle.
    opcode  = 7'b0110011;
    data_in = 32'hA5A5A5A5;
    req_in  = 1'b1;
    ack_in  = 3'b100;
    step();
    check("preack_req_state_ack", ack_out, 1'b0);
    check("preack_req_out", req_out, 3'b100);
    step();
    check("preack_ack_out", ack_out, 1'b1);
    // Ack already low on RTZ entry: one RTZ cycle, then IDLE.
    req_in = 1'b0;
    ack_in = 3'b000;
    step();
    check("fast_rtz_ack_out", ack_out, 1'b1);
    check("fast_rtz_busy", busy, 1'b1);
    step();
    check("fast_rtz_idle_ack", ack_out, 1'b0);
    check("fast_rtz_idle_busy", busy, 1'b0);

    // Spurious acks on unselected channels must not advance REQ.
    opcode  = 7'b0000011;
    data_in = 32'h0BADF00D;
    req_in  = 1'b1;
    ack_in  = 3'b000;
    step();
    ack_in = 3'b101;
    step();
    check("spurious_ack_out", ack_out, 1'b0);
    check("spurious_req_out", req_out, 3'b010);
    ack_in = 3'b010;
    step();
    check("spurious_then_ack", ack_out, 1'b1);

    // Reset while in ACK.
    rst_n = 1'b0;
    step();
    check("midrst_req_out", req_out, '0);
    check("midrst_ack_out", ack_out, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_data_out", data_out, '0);
    check("midrst_err_timeout", err_timeout, 1'b0);
    rst_n  = 1'b1;
    req_in = 1'b0;
    ack_in = '0;
    step();

    // Watchdog: selected ack withheld; flag after TO cycles in REQ, then sticky.
    opcode  = 7'b1100011;
    data_in = 32'hCAFEF00D;
    req_in  = 1'b1;
    step();
    for (int k = 1; k <= TO; k++) begin
      check("wd_before_limit", err_timeout, 1'b0);
      ack_in = 3'b110;
      step();
    end
    check("wd_set", err_timeout, 1'b1);
    step();
    check("wd_still_waiting", req_out, 3'b001);
    ack_in = 3'b001;
    step();
    check("wd_late_ack", ack_out, 1'b1);
    req_in = 1'b0;
    step();
    ack_in = 3'b000;
    step();
    check("wd_done_busy", busy, 1'b0);
    check("wd_sticky", err_timeout, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
